// File: rtl/magic_nor_executor.sv
// MAGIC-style in-memory executor: loads primary inputs into a bit-cell row, runs
// inv1/nor2 micro-ops one per cycle, and snapshots a fixed output window on END.
`timescale 1ns/1ps

module magic_nor_executor #(
    parameter int NUM_CELLS = 100,
    parameter int ADDR_W    = 7,
    parameter int NUM_IN    = 10,
    parameter int NUM_OUT   = 7,
    parameter int OUT_BASE  = 93,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_data,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_code,
    input  logic [ADDR_W-1:0]  op_a,
    input  logic [ADDR_W-1:0]  op_b,
    input  logic [ADDR_W-1:0]  op_dst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   gate_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_INV   = 2'b00;
    localparam logic [1:0] OP_NOR2  = 2'b01;
    localparam logic [1:0] OP_INIT1 = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam logic [ADDR_W:0] CELL_LIMIT = (ADDR_W+1)'(NUM_CELLS);

    logic [1:0]           state_q, state_d;
    logic [NUM_CELLS-1:0] cells_q, cells_d;
    logic [NUM_OUT-1:0]   out_data_q, out_data_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     gate_count_q, gate_count_d;

    logic a_ok, b_ok, dst_ok, range_bad;
    logic a_bit, b_bit, dst_bit;

    // Out-of-range reads are masked so a bad address never indexes past the row.
    always_comb begin
        a_ok    = {1'b0, op_a} < CELL_LIMIT;
        b_ok    = {1'b0, op_b} < CELL_LIMIT;
        dst_ok  = {1'b0, op_dst} < CELL_LIMIT;
        a_bit   = a_ok ? cells_q[op_a] : 1'b0;
        b_bit   = b_ok ? cells_q[op_b] : 1'b0;
        dst_bit = dst_ok ? cells_q[op_dst] : 1'b0;
        case (op_code)
            OP_INV:   range_bad = !(a_ok && dst_ok);
            OP_NOR2:  range_bad = !(a_ok && b_ok && dst_ok);
            OP_INIT1: range_bad = !dst_ok;
            default:  range_bad = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cells_d      = cells_q;
        out_data_d   = out_data_q;
        err_d        = err_q;
        gate_count_d = gate_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cells_d              = '0;
                    cells_d[NUM_IN-1:0]  = in_data;
                    err_d                = 1'b0;
                    gate_count_d         = '0;
                    state_d              = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_valid) begin
                    if (op_code == OP_END) begin
                        out_data_d = cells_q[OUT_BASE +: NUM_OUT];
                        state_d    = ST_DONE;
                    end else if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        // MAGIC write: a gate can only pull its output cell from 1 to 0.
                        case (op_code)
                            OP_INIT1: cells_d[op_dst] = 1'b1;
                            OP_INV:   cells_d[op_dst] = dst_bit & ~a_bit;
                            OP_NOR2:  cells_d[op_dst] = dst_bit & ~(a_bit | b_bit);
                            default:  cells_d[op_dst] = dst_bit;
                        endcase
                        if (op_code != OP_INIT1 && gate_count_q != {CNT_W{1'b1}})
                            gate_count_d = gate_count_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
        if (rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the cell row is a flop array, not RAM, so clearing it on reset is cheap and defined.
            cells_q      <= '0;
            out_data_q   <= '0;
            err_q        <= 1'b0;
            gate_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cells_q      <= cells_d;
            out_data_q   <= out_data_d;
            err_q        <= err_d;
            gate_count_q <= gate_count_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign op_ready   = (state_q == ST_EXEC);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign out_data   = out_data_q;
    assign err        = err_q;
    assign gate_count = gate_count_q;

endmodule

// File: tb/tb_magic_nor_executor.sv
// Scoreboard bench for magic_nor_executor: directed netlists push expected results,
// a negedge monitor pops and compares on every result handshake.
`timescale 1ns/1ps

module tb_magic_nor_executor;

    localparam logic [1:0] C_INV   = 2'b00;
    localparam logic [1:0] C_NOR2  = 2'b01;
    localparam logic [1:0] C_INIT1 = 2'b10;
    localparam logic [1:0] C_END   = 2'b11;

    typedef struct packed {
        logic [6:0]  data;
        logic        err;
        logic [15:0] gc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic        clk, rst;
    logic        in_valid, in_ready, op_valid, op_ready, out_valid, out_ready, busy, err;
    logic [9:0]  in_data;
    logic [1:0]  op_code;
    logic [6:0]  op_a, op_b, op_dst, out_data;
    logic [15:0] gate_count;

    logic        in_valid_s, in_ready_s, op_valid_s, op_ready_s, out_valid_s, out_ready_s, busy_s, err_s;
    logic [9:0]  in_data_s;
    logic [1:0]  op_code_s;
    logic [6:0]  op_a_s, op_b_s, op_dst_s, out_data_s;
    logic [1:0]  gate_count_s;

    magic_nor_executor dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err), .gate_count(gate_count)
    );

    magic_nor_executor #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .op_valid(op_valid_s), .op_ready(op_ready_s), .op_code(op_code_s),
        .op_a(op_a_s), .op_b(op_b_s), .op_dst(op_dst_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
        .busy(busy_s), .err(err_s), .gate_count(gate_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("load_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("load_to_exec", 32'(op_ready), 1);
    endtask

    task automatic op(input logic [1:0] c, input logic [6:0] a, input logic [6:0] b, input logic [6:0] d);
        op_valid = 1'b1;
        op_code  = c;
        op_a     = a;
        op_b     = b;
        op_dst   = d;
        check("op_ready", 32'(op_ready), 1);
        tick();
    endtask

    task automatic finish_run(input exp_t e);
        sb_q.push_back(e);
        op(C_END, 7'd0, 7'd0, 7'd0);
        op_valid = 1'b0;
        check("end_to_out_valid", 32'(out_valid), 1);
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("err", 32'(err), 32'(e.err));
                check("gate_count", 32'(gate_count), 32'(e.gc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; op_valid = 1'b0; op_code = '0;
        op_a = '0; op_b = '0; op_dst = '0; out_ready = 1'b1;
        in_valid_s = 1'b0; in_data_s = '0; op_valid_s = 1'b0; op_code_s = '0;
        op_a_s = '0; op_b_s = '0; op_dst_s = '0; out_ready_s = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_op_ready", 32'(op_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);

        // Reset mid-EXEC with ops still streaming
        load(10'h3FF);
        op(C_INV, 7'd0, 7'd0, 7'd93);
        op(C_INIT1, 7'd0, 7'd0, 7'd110);
        check("pre_rst_err", 32'(err), 1);
        check("pre_rst_gc", 32'(gate_count), 1);
        op_valid = 1'b1;
        op_code  = C_INV;
        op_a     = 7'd1;
        op_dst   = 7'd94;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        op_valid = 1'b0;
        check("rst2_in_ready", 32'(in_ready), 1);
        check("rst2_op_ready", 32'(op_ready), 0);
        check("rst2_out_valid", 32'(out_valid), 0);
        check("rst2_err", 32'(err), 0);
        check("rst2_gc", 32'(gate_count), 0);
        check("rst2_busy", 32'(busy), 0);

        // Basic netlist
        load(10'b0000000010);
        op(C_INIT1, 7'd0, 7'd0, 7'd93);
        op(C_NOR2,  7'd0, 7'd1, 7'd93);
        op(C_INIT1, 7'd0, 7'd0, 7'd94);
        op(C_INV,   7'd93, 7'd0, 7'd94);
        op(C_INIT1, 7'd0, 7'd0, 7'd95);
        op(C_NOR2,  7'd0, 7'd2, 7'd95);
        check("basic_no_early_valid", 32'(out_valid), 0);
        finish_run(exp_t'{data: 7'b0000110, err: 1'b0, gc: 16'd3});

        // MAGIC non-initialised destination stays 0
        load(10'd0);
        op(C_NOR2, 7'd0, 7'd1, 7'd93);
        finish_run(exp_t'{data: 7'b0000000, err: 1'b0, gc: 16'd1});

        // Range error: op consumed with no write and no count
        load(10'd0);
        op(C_INIT1, 7'd0, 7'd0, 7'd93);
        op(C_NOR2, 7'd100, 7'd0, 7'd93);
        check("range_err_set", 32'(err), 1);
        check("range_op_ready", 32'(op_ready), 1);
        op(C_INIT1, 7'd0, 7'd0, 7'd120);
        finish_run(exp_t'{data: 7'b0000001, err: 1'b1, gc: 16'd0});
        check("range_err_in_done", 32'(err), 1);

        // Back-to-back read-after-write
        load(10'd0);
        op(C_INIT1, 7'd0, 7'd0, 7'd51);
        op(C_INIT1, 7'd0, 7'd0, 7'd50);
        op(C_INV,   7'd50, 7'd0, 7'd51);
        op(C_INIT1, 7'd0, 7'd0, 7'd96);
        op(C_INV,   7'd51, 7'd0, 7'd96);
        op(C_INIT1, 7'd0, 7'd0, 7'd97);
        op(C_INV,   7'd50, 7'd0, 7'd97);
        finish_run(exp_t'{data: 7'b0001000, err: 1'b0, gc: 16'd3});

        // Backpressure, with a gate writing an input cell
        load(10'h3FF);
        op(C_INIT1, 7'd0, 7'd0, 7'd99);
        op(C_INV,   7'd0, 7'd0, 7'd99);
        op(C_INIT1, 7'd0, 7'd0, 7'd98);
        op(C_NOR2,  7'd1, 7'd2, 7'd3);
        op(C_INIT1, 7'd0, 7'd0, 7'd97);
        op(C_INV,   7'd3, 7'd0, 7'd97);
        out_ready = 1'b0;
        finish_run(exp_t'{data: 7'b0110000, err: 1'b0, gc: 16'd3});
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_data", 32'(out_data), 32'(7'b0110000));
            check("bp_op_ready", 32'(op_ready), 0);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle_after_hs", 32'(in_ready), 1);
        check("bp_valid_dropped", 32'(out_valid), 0);

        // Gate counter saturation on the 2-bit instance
        in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        op_valid_s = 1'b1;
        op_code_s  = C_INV;
        op_a_s     = 7'd0;
        op_dst_s   = 7'd1;
        for (int i = 0; i < 5; i++) tick();
        op_valid_s = 1'b0;
        check("sat_gate_count", 32'(gate_count_s), 3);
        check("sat_err", 32'(err_s), 0);

        tick();
        tick();
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
